// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, opcodes and PC helpers.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  localparam int unsigned PcWidth   = 8;
  localparam int unsigned InstWidth = 8;
  localparam int unsigned MemDepth  = 256;

  localparam logic [InstWidth-1:0] NOP_OP          = 8'h00;
  localparam logic [InstWidth-1:0] DEFAULT_HALT_OP = 8'hFF;

  // Wraps 8'hFF to 8'h00 by plain modulo-256 truncation.
  function automatic logic [PcWidth-1:0] pc_inc(input logic [PcWidth-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// 256x8 instruction memory: asynchronous read, synchronous write, never cleared.
module instr_mem
  import instr_fetch_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [PcWidth-1:0]   i_waddr,
  input  logic [InstWidth-1:0] i_wdata,
  input  logic [PcWidth-1:0]   i_raddr,
  output logic [InstWidth-1:0] o_rdata
);

  logic [InstWidth-1:0] r_mem [MemDepth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write to the address being read shows up only after the edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, BOOT/RUN/HALT sequencing, redirect flush and instruction memory.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = DEFAULT_HALT_OP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       stall,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] PC,
  output logic [7:0] instrCode,
  output logic       flush,
  output logic       halted
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [7:0]   r_pc;
  logic [7:0]   w_pc_nxt;
  logic [7:0]   w_rdata;

  instr_mem u_instr_mem (
    .i_clk   (Clk),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      StBoot: begin
        w_state_nxt = StRun;
      end
      StRun: begin
        if (jump_en) begin
          w_pc_nxt = jump_target;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_rdata == HALT_OP) begin
          w_state_nxt = StHalt;
        end else begin
          w_pc_nxt = pc_inc(r_pc);
        end
      end
      StHalt: begin
        if (jump_en) begin
          w_pc_nxt    = jump_target;
          w_state_nxt = StRun;
        end
      end
      default: begin
        w_state_nxt = StBoot;
      end
    endcase
  end

  // Only RUN presents real opcodes; BOOT, HALT and the illegal encoding issue NOPs.
  assign instrCode = (r_state == StRun) ? w_rdata : NOP_OP;
  assign flush     = jump_en & ((r_state == StRun) | (r_state == StHalt));
  assign halted    = (r_state == StHalt);
  assign PC        = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic against a model.
module tb_instr_fetch;

  localparam int ModeBoot = 0;
  localparam int ModeRun  = 1;
  localparam int ModeHalt = 2;

  logic       Clk;
  logic       Reset;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] PC;
  logic [7:0] instrCode;
  logic       flush;
  logic       halted;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  int         m_mode;

  instr_fetch #(
    .RESET_PC (8'h00),
    .HALT_OP  (8'hFF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .PC          (PC),
    .instrCode   (instrCode),
    .flush       (flush),
    .halted      (halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, check the settled outputs, then step the model.
  task automatic cyc(input logic rst, input logic st, input logic je, input logic [7:0] jt,
                     input logic we, input logic [7:0] wa, input logic [7:0] wd);
    logic [7:0] e_instr;
    logic [7:0] n_pc;
    int         n_mode;
    Reset = rst; stall = st; jump_en = je; jump_target = jt;
    prog_we = we; prog_addr = wa; prog_data = wd;
    #1;
    e_instr = (m_mode == ModeRun) ? m_mem[m_pc] : 8'h00;
    check("pc",     {24'd0, PC},        {24'd0, m_pc});
    check("instr",  {24'd0, instrCode}, {24'd0, e_instr});
    check("flush",  {31'd0, flush},     {31'd0, je && (m_mode != ModeBoot)});
    check("halted", {31'd0, halted},    {31'd0, m_mode == ModeHalt});

    n_pc   = m_pc;
    n_mode = m_mode;
    if (rst) begin
      n_pc   = 8'h00;
      n_mode = ModeBoot;
    end else if (m_mode == ModeBoot) begin
      n_mode = ModeRun;
    end else if (je) begin
      n_pc   = jt;
      n_mode = ModeRun;
    end else if (m_mode == ModeRun && !st) begin
      if (m_mem[m_pc] == 8'hFF) n_mode = ModeHalt;
      else n_pc = 8'((int'(m_pc) + 1) % 256);
    end
    @(posedge Clk);
    m_pc   = n_pc;
    m_mode = n_mode;
    if (we) m_mem[wa] = wd;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic jump(input logic [7:0] tgt);
    cyc(1'b0, 1'b0, 1'b1, tgt, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    Reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    // First edge brings the DUT out of its unknown power-up state; nothing to compare yet.
    @(posedge Clk);
    @(negedge Clk);
    m_pc   = 8'h00;
    m_mode = ModeBoot;

    // Program the whole memory while reset is held; jump_en under reset must not flush.
    for (int a = 0; a < 256; a++) begin
      case (a)
        0: d = 8'h11;
        1: d = 8'h22;
        2: d = 8'h33;
        3: d = 8'hFF;
        default: begin
          d = 8'($urandom_range(0, 254));
        end
      endcase
      cyc(1'b1, a[0], a[1], 8'h55, 1'b1, 8'(a), d);
    end

    // BOOT, then 0..3 fetching 11,22,33,FF, then HALT parked at 3.
    idle(8);
    // Leave HALT to PC=05, then redirect to 40 with flush.
    jump(8'h05);
    jump(8'h40);
    idle(1);
    // Three-cycle stall at 07, then resume.
    jump(8'h07);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    idle(2);
    // Jump and stall together at 07.
    jump(8'h07);
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 8'h00);
    idle(1);
    // Wrap-around from FF; runs on into the halt at 03.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h12);
    jump(8'hFF);
    idle(7);
    // From HALT to 10 while stall is also high (stall ignored).
    cyc(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    // Overwrite mem[PC] under stall: old value now, AB next cycle.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'hAB);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    // Reset during a stall with a jump pending.
    cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 8'h00);
    idle(3);

    // Random traffic, including occasional HALT opcodes and resets.
    for (int i = 0; i < 1500; i++) begin
      logic       r_rst;
      logic       r_st;
      logic       r_je;
      logic       r_we;
      logic [7:0] r_wd;
      r_rst = ($urandom_range(0, 63) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_je  = ($urandom_range(0, 7) == 0);
      r_we  = ($urandom_range(0, 3) == 0);
      r_wd  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      cyc(r_rst, r_st, r_je, 8'($urandom), r_we, ($urandom_range(0, 1) == 0) ? PC : 8'($urandom),
          r_wd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
